// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, lock FSM states and word-level decode helpers
// used by the receive channel decoder.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    HOLDOFF = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } tmds_lock_state_t;

  function automatic logic is_ctrl_token(input logic [9:0] w);
    logic hit_s;
    case (w)
      TMDS_CTRL_00, TMDS_CTRL_01, TMDS_CTRL_10, TMDS_CTRL_11: hit_s = 1'b1;
      default:                                                hit_s = 1'b0;
    endcase
    return hit_s;
  endfunction

  function automatic logic [1:0] ctrl_token_value(input logic [9:0] w);
    logic [1:0] ctrl_s;
    case (w)
      TMDS_CTRL_00: ctrl_s = 2'b00;
      TMDS_CTRL_01: ctrl_s = 2'b01;
      TMDS_CTRL_10: ctrl_s = 2'b10;
      TMDS_CTRL_11: ctrl_s = 2'b11;
      default:      ctrl_s = 2'b00;
    endcase
    return ctrl_s;
  endfunction

  // Undo the transmitter's optional inversion (bit 9) of the payload byte.
  function automatic logic [7:0] tmds_unmask(input logic [9:0] w);
    return w[9] ? ~w[7:0] : w[7:0];
  endfunction

  function automatic logic [7:0] tmds_decode_word(input logic [9:0] w);
    logic [7:0] q_s;
    logic [7:0] d_s;
    q_s    = tmds_unmask(w);
    d_s    = 8'h00;
    d_s[0] = q_s[0];
    for (int i = 1; i < 8; i++) begin
      d_s[i] = w[8] ? (q_s[i] ^ q_s[i-1]) : ~(q_s[i] ^ q_s[i-1]);
    end
    return d_s;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt_s;
    cnt_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_s = cnt_s + {3'b000, v[i]};
    end
    return cnt_s;
  endfunction

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] cnt_s;
    cnt_s = 4'd0;
    for (int i = 0; i < 10; i++) begin
      cnt_s = cnt_s + {3'b000, v[i]};
    end
    return cnt_s;
  endfunction

  // Invert decision the encoder should have made for this byte given the running tally.
  function automatic logic expected_inv(input logic signed [5:0] tally,
                                        input logic [3:0]        n1,
                                        input logic              w8);
    logic inv_s;
    if ((tally == 6'sd0) || (n1 == 4'd4)) begin
      inv_s = ~w8;
    end else begin
      inv_s = ((tally > 6'sd0) && (n1 > 4'd4)) || ((tally < 6'sd0) && (n1 < 4'd4));
    end
    return inv_s;
  endfunction

endpackage

// File: rtl/tmds_decoder_if.sv
// Channel-side bundle of the TMDS decoder: received word in, decoded fields and
// alignment handshake out.
interface tmds_decoder_if;
  logic [9:0] i_tmds;
  logic [7:0] o_data;
  logic [1:0] o_control;
  logic       o_de;
  logic       o_disp_err;
  logic       o_locked;
  logic       o_bitslip;

  modport master (
    output i_tmds,
    input  o_data, o_control, o_de, o_disp_err, o_locked, o_bitslip
  );

  modport slave (
    input  i_tmds,
    output o_data, o_control, o_de, o_disp_err, o_locked, o_bitslip
  );
endinterface

// File: rtl/tmds_lock_fsm.sv
// Word-alignment lock FSM: hunts for repeating control tokens, requests bitslips when
// none appear, and drops lock after a long token-free stretch.
module tmds_lock_fsm
  import tmds_pkg::*;
#(
  parameter int SEARCH_TIMEOUT  = 2048,
  parameter int LOCK_TOKENS     = 8,
  parameter int BITSLIP_HOLDOFF = 16,
  parameter int LOSS_TIMEOUT    = 4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_token,
  output logic o_locked,
  output logic o_bitslip
);

  localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int TW = $clog2(LOCK_TOKENS + 1);
  localparam int HW = $clog2(BITSLIP_HOLDOFF + 1);
  localparam int LW = $clog2(LOSS_TIMEOUT + 1);

  // Each timer expires on the cycle its count already holds PARAM-1 idle cycles.
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] TOK_LAST    = TW'(LOCK_TOKENS - 1);
  localparam logic [TW-1:0] TOK_FULL    = TW'(LOCK_TOKENS);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(BITSLIP_HOLDOFF - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_TIMEOUT - 1);

  tmds_lock_state_t state_r, state_nxt_s;
  logic [SW-1:0]    search_cnt_r, search_cnt_nxt_s;
  logic [TW-1:0]    tok_cnt_r, tok_cnt_nxt_s;
  logic [HW-1:0]    hold_cnt_r, hold_cnt_nxt_s;
  logic [LW-1:0]    loss_cnt_r, loss_cnt_nxt_s;
  logic             locked_r, bitslip_r, bitslip_nxt_s;

  // State, counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= SEARCH;
      search_cnt_r <= '0;
      tok_cnt_r    <= '0;
      hold_cnt_r   <= '0;
      loss_cnt_r   <= '0;
      locked_r     <= 1'b0;
      bitslip_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      search_cnt_r <= search_cnt_nxt_s;
      tok_cnt_r    <= tok_cnt_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      loss_cnt_r   <= loss_cnt_nxt_s;
      locked_r     <= (state_nxt_s == LOCKED);
      bitslip_r    <= bitslip_nxt_s;
    end
  end

  // Next-state and counter update; a token always beats a coincident timeout.
  always_comb begin
    state_nxt_s      = state_r;
    search_cnt_nxt_s = search_cnt_r;
    tok_cnt_nxt_s    = tok_cnt_r;
    hold_cnt_nxt_s   = hold_cnt_r;
    loss_cnt_nxt_s   = loss_cnt_r;
    bitslip_nxt_s    = 1'b0;
    case (state_r)
      SEARCH: begin
        if (i_token) begin
          state_nxt_s      = VERIFY;
          tok_cnt_nxt_s    = TW'(1);
          search_cnt_nxt_s = '0;
        end else if (search_cnt_r >= SEARCH_LAST) begin
          state_nxt_s      = HOLDOFF;
          bitslip_nxt_s    = 1'b1;
          search_cnt_nxt_s = '0;
          hold_cnt_nxt_s   = '0;
        end else begin
          search_cnt_nxt_s = search_cnt_r + SW'(1);
        end
      end
      HOLDOFF: begin
        if (hold_cnt_r >= HOLD_LAST) begin
          state_nxt_s      = SEARCH;
          hold_cnt_nxt_s   = '0;
          search_cnt_nxt_s = '0;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HW'(1);
        end
      end
      VERIFY: begin
        if (i_token) begin
          if (tok_cnt_r >= TOK_LAST) begin
            state_nxt_s    = LOCKED;
            tok_cnt_nxt_s  = TOK_FULL;
            loss_cnt_nxt_s = '0;
          end else begin
            tok_cnt_nxt_s = tok_cnt_r + TW'(1);
          end
        end else begin
          state_nxt_s      = SEARCH;
          tok_cnt_nxt_s    = '0;
          search_cnt_nxt_s = '0;
        end
      end
      LOCKED: begin
        if (i_token) begin
          loss_cnt_nxt_s = '0;
        end else if (loss_cnt_r >= LOSS_LAST) begin
          state_nxt_s      = SEARCH;
          loss_cnt_nxt_s   = '0;
          tok_cnt_nxt_s    = '0;
          search_cnt_nxt_s = '0;
        end else begin
          loss_cnt_nxt_s = loss_cnt_r + LW'(1);
        end
      end
      default: begin
        state_nxt_s      = SEARCH;
        search_cnt_nxt_s = '0;
        tok_cnt_nxt_s    = '0;
        hold_cnt_nxt_s   = '0;
        loss_cnt_nxt_s   = '0;
      end
    endcase
  end

  assign o_locked  = locked_r;
  assign o_bitslip = bitslip_r;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: token detection, 10b->8b decode, DC-balance check and
// registered outputs, with alignment handled by tmds_lock_fsm.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_TIMEOUT  = 2048,
  parameter int LOCK_TOKENS     = 8,
  parameter int BITSLIP_HOLDOFF = 16,
  parameter int LOSS_TIMEOUT    = 4096
) (
  input  logic           i_clk,
  input  logic           i_rst,
  tmds_decoder_if.slave  bus
);

  logic [9:0]        w_s;
  logic              token_s;
  logic [7:0]        q_s;
  logic [7:0]        d_s;
  logic [3:0]        n1_s;
  logic [3:0]        pop_w_s;
  logic              inv_s;
  logic signed [5:0] delta_s;
  logic signed [5:0] tally_nxt_s;
  logic              locked_s;
  logic              bitslip_s;

  logic [7:0]        data_r;
  logic [1:0]        control_r;
  logic              de_r;
  logic              disp_err_r;
  logic signed [5:0] tally_r;

  // Word classification, decode and expected DC-balance decision.
  always_comb begin
    w_s         = bus.i_tmds;
    token_s     = is_ctrl_token(w_s);
    q_s         = tmds_unmask(w_s);
    d_s         = tmds_decode_word(w_s);
    n1_s        = popcount8(q_s);
    pop_w_s     = popcount10(w_s);
    inv_s       = expected_inv(tally_r, n1_s, w_s[8]);
    delta_s     = $signed({1'b0, pop_w_s, 1'b0}) - 6'sd10;
    tally_nxt_s = tally_r + delta_s;
  end

  tmds_lock_fsm #(
    .SEARCH_TIMEOUT  (SEARCH_TIMEOUT),
    .LOCK_TOKENS     (LOCK_TOKENS),
    .BITSLIP_HOLDOFF (BITSLIP_HOLDOFF),
    .LOSS_TIMEOUT    (LOSS_TIMEOUT)
  ) u_lock (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_token   (token_s),
    .o_locked  (locked_s),
    .o_bitslip (bitslip_s)
  );

  // Output registers and running tally; o_de follows the lock state held before this word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_r     <= 8'h00;
      control_r  <= 2'b00;
      de_r       <= 1'b0;
      disp_err_r <= 1'b0;
      tally_r    <= 6'sd0;
    end else if (token_s) begin
      data_r     <= 8'h00;
      control_r  <= ctrl_token_value(w_s);
      de_r       <= 1'b0;
      disp_err_r <= 1'b0;
      tally_r    <= 6'sd0;
    end else begin
      data_r     <= locked_s ? d_s : 8'h00;
      control_r  <= control_r;
      de_r       <= locked_s;
      disp_err_r <= locked_s & (w_s[9] != inv_s);
      tally_r    <= tally_nxt_s;
    end
  end

  assign bus.o_data     = data_r;
  assign bus.o_control  = control_r;
  assign bus.o_de       = de_r;
  assign bus.o_disp_err = disp_err_r;
  assign bus.o_locked   = locked_s;
  assign bus.o_bitslip  = bitslip_s;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, lock, decode, disparity, bitslip, verify abort
// and loss of lock, with hand-computed expectations.
module tb_tmds_decoder;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  tmds_decoder_if bus ();

  tmds_decoder dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] w);
    bus.i_tmds = w;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] data, input logic [1:0] ctrl,
                         input logic de, input logic err, input logic lck, input logic slip);
    chk({tag, ".data"},     {8'h00, bus.o_data},          {8'h00, data});
    chk({tag, ".control"},  {14'h0, bus.o_control},       {14'h0, ctrl});
    chk({tag, ".de"},       {15'h0, bus.o_de},            {15'h0, de});
    chk({tag, ".disp_err"}, {15'h0, bus.o_disp_err},      {15'h0, err});
    chk({tag, ".locked"},   {15'h0, bus.o_locked},        {15'h0, lck});
    chk({tag, ".bitslip"},  {15'h0, bus.o_bitslip},       {15'h0, slip});
  endtask

  initial begin
    int first_slip;
    int n_slip;
    int consec;
    int quiet_bad;
    int de_seen;
    logic prev_slip;

    bus.i_tmds = 10'h354;

    // Reset held for three cycles with a token on the input.
    for (int i = 0; i < 3; i++) begin
      step(10'h354);
      chk_all("reset", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Only data words: bitslip at cycle 2048, quiet holdoff, then repeats.
    i_rst      = 1'b0;
    first_slip = 0;
    n_slip     = 0;
    consec     = 0;
    quiet_bad  = 0;
    de_seen    = 0;
    prev_slip  = 1'b0;
    for (int c = 1; c <= 4200; c++) begin
      step(10'h100);
      if (bus.o_bitslip === 1'b1) begin
        n_slip++;
        if (first_slip == 0) first_slip = c;
        if (prev_slip) consec++;
        if ((first_slip != c) && (c <= first_slip + 16)) quiet_bad++;
      end
      if (bus.o_de !== 1'b0) de_seen++;
      prev_slip = bus.o_bitslip;
    end
    chk("slip.first_cycle", first_slip[15:0], 16'd2048);
    chk("slip.count",       n_slip[15:0],     16'd2);
    chk("slip.consecutive", consec[15:0],     16'd0);
    chk("slip.holdoff",     quiet_bad[15:0],  16'd0);
    chk("slip.de_low",      de_seen[15:0],    16'd0);

    // Mid-operation reset clears everything even with a token present.
    i_rst = 1'b1;
    step(10'h354);
    chk_all("reset_mid", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;

    // Token on the cycle the search timer would expire wins over the bitslip.
    for (int i = 0; i < 2047; i++) step(10'h100);
    chk("pre_timeout.bitslip", {15'h0, bus.o_bitslip}, 16'h0);
    step(10'h0AB);
    chk_all("token_wins", 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Verify abort after five 0x0AB tokens: no lock, no bitslip.
    for (int i = 0; i < 4; i++) step(10'h0AB);
    chk("verify5.locked", {15'h0, bus.o_locked}, 16'h0);
    step(10'h100);
    chk_all("verify_abort", 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lock after eight 0x354 tokens.
    for (int i = 0; i < 7; i++) step(10'h354);
    chk("lock7.locked", {15'h0, bus.o_locked}, 16'h0);
    step(10'h354);
    chk_all("lock8", 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10'h100);
    chk_all("data_100a", 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(10'h3FF);
    chk_all("data_3ff",  8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(10'h100);
    chk_all("data_100b", 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);

    // Disparity error: tally -8 after first 0x100 demands inversion on the second.
    step(10'h354);
    chk_all("disp_tok", 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10'h100);
    chk("disp_w1.err", {15'h0, bus.o_disp_err}, 16'h0);
    step(10'h100);
    chk_all("disp_w2", 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

    // Non-trivial decodes from a zero tally.
    step(10'h354);
    step(10'h0FF);
    chk_all("dec_0ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(10'h155);
    chk_all("dec_155", 8'hFF, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(10'h2AA);
    chk_all("dec_2aa", 8'h01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(10'h154);
    chk_all("tok_154", 8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10'h2AB);
    chk_all("tok_2ab", 8'h00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(10'h100);
    chk_all("ctrl_hold", 8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);

    // Loss of lock: token on cycle 4096 rescues lock; a full 4096 data words drops it.
    step(10'h354);
    de_seen = 0;
    for (int i = 0; i < 4095; i++) begin
      step(10'h100);
      if (bus.o_de !== 1'b1) de_seen++;
    end
    chk("loss4095.locked", {15'h0, bus.o_locked}, 16'h1);
    chk("loss4095.de_gaps", de_seen[15:0], 16'd0);
    step(10'h354);
    chk("loss_rescue.locked", {15'h0, bus.o_locked}, 16'h1);
    for (int i = 0; i < 4095; i++) step(10'h100);
    chk("loss_b4095.locked", {15'h0, bus.o_locked}, 16'h1);
    step(10'h100);
    chk("loss_drop.locked", {15'h0, bus.o_locked}, 16'h0);
    step(10'h155);
    chk_all("after_loss", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while locked leaves no lock behind.
    for (int i = 0; i < 8; i++) step(10'h2AB);
    chk("relock.locked", {15'h0, bus.o_locked}, 16'h1);
    i_rst = 1'b1;
    step(10'h155);
    chk_all("reset_locked", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    step(10'h100);
    chk_all("post_reset", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
